hilo_muldiv_unit: RTL and testbench

//   Parametrised multiply/divide engine owning the architectural HI/LO registers.

---
 rtl/mips_defs_pkg.sv | 26 ++
 rtl/div_iter.sv | 72 +++++++
 rtl/hilo_muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// No logic: opcode encodings, FSM state type and default datapath width.
// No flow control of its own.
package mips_defs_pkg;

    localparam int HILO_W = 32;

    localparam logic [2:0] MD_OP_MULT  = 3'd0;
    localparam logic [2:0] MD_OP_MULTU = 3'd1;
    localparam logic [2:0] MD_OP_DIV   = 3'd2;
    localparam logic [2:0] MD_OP_DIVU  = 3'd3;
    localparam logic [2:0] MD_OP_MTHI  = 3'd4;
    localparam logic [2:0] MD_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_t;

    // Multi-cycle ops are the ones that stall the pipeline.
    function automatic logic op_is_md(input logic [2:0] op);
        return op <= MD_OP_DIVU;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider with sign fix-up; quotient/remainder valid while done is high.
// Latency: WIDTH cycles after start, or the start cycle itself for a zero divisor.
// No backpressure: start is only pulsed when idle, flush aborts immediately.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             active;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             neg_q, neg_r;

    logic             a_neg, b_neg, div_zero, last;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_n, quo_n;

    assign a_neg    = is_signed & dividend[WIDTH-1];
    assign b_neg    = is_signed & divisor[WIDTH-1];
    assign div_zero = start & (divisor == '0);

    // Quotient bits shift out of quo_q's MSB into the partial remainder.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign rem_n   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_n   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

    assign last      = active & (cnt == CW'(1));
    assign done      = div_zero | last;
    assign quotient  = div_zero ? '1 : (neg_q ? -quo_n : quo_n);
    assign remainder = div_zero ? dividend : (neg_r ? -rem_n : rem_n);

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            active <= 1'b0;
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (flush) begin
            active <= 1'b0;
        end else if (start && !div_zero) begin
            active <= 1'b1;
            cnt    <= CW'(WIDTH);
            rem_q  <= '0;
            quo_q  <= a_neg ? -dividend : dividend;
            dvs_q  <= b_neg ? -divisor : divisor;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
        end else if (active) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt   <= cnt - 1'b1;
            if (last) active <= 1'b0;
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multiply/divide engine owning HI/LO; MULT/MULTU/DIV/DIVU multi-cycle, MTHI/MTLO single-cycle.
// Latency: MUL_STAGES cycles for multiply, WIDTH+1 for divide (1 on zero divisor), 1 for MT.
// Backpressure: busy stalls the pipeline from the issue cycle; starts while busy are dropped.
import mips_defs_pkg::*;

module hilo_muldiv_unit #(
    parameter int WIDTH      = HILO_W,
    parameter int MUL_STAGES = 2
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(MUL_STAGES + 1);

    md_state_t          state;
    logic [CW-1:0]      mul_cnt;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               accept, mul_signed, div_signed, div_start, div_done;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod_now, prod_last;
    logic [WIDTH-1:0]   div_q, div_r;

    assign accept     = start_i & ~flush_i & (state == IDLE);
    assign mul_signed = (op_i == MD_OP_MULT);
    assign div_signed = (op_i == MD_OP_DIV);
    assign div_start  = accept & ((op_i == MD_OP_DIV) | (op_i == MD_OP_DIVU));

    // Sign- or zero-extension lets one 2W x 2W product serve both MULT and MULTU.
    assign ext_a    = {{WIDTH{mul_signed & src_a_i[WIDTH-1]}}, src_a_i};
    assign ext_b    = {{WIDTH{mul_signed & src_b_i[WIDTH-1]}}, src_b_i};
    assign prod_now = ext_a * ext_b;

    generate
        if (MUL_STAGES > 1) begin : g_pipe
            logic [2*WIDTH-1:0] pipe [MUL_STAGES-1];
            always_ff @(posedge clka) begin
                pipe[0] <= prod_now;
                for (int i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
            end
            assign prod_last = pipe[MUL_STAGES-2];
        end else begin : g_nopipe
            assign prod_last = prod_now;
        end
    endgenerate

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clka      (clka),
        .rst       (rst),
        .start     (div_start),
        .flush     (flush_i),
        .is_signed (div_signed),
        .dividend  (src_a_i),
        .divisor   (src_b_i),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mul_cnt <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state   <= IDLE;
                mul_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: if (start_i) begin
                        case (op_i)
                            MD_OP_MULT, MD_OP_MULTU: begin
                                if (MUL_STAGES == 1) begin
                                    {hi_q, lo_q} <= prod_now;
                                    done_q       <= 1'b1;
                                end else begin
                                    state   <= MUL;
                                    mul_cnt <= CW'(1);
                                end
                            end
                            MD_OP_DIV, MD_OP_DIVU: begin
                                if (div_done) begin
                                    hi_q   <= div_r;
                                    lo_q   <= div_q;
                                    done_q <= 1'b1;
                                end else begin
                                    state <= DIV;
                                end
                            end
                            MD_OP_MTHI: begin
                                hi_q   <= src_a_i;
                                done_q <= 1'b1;
                            end
                            MD_OP_MTLO: begin
                                lo_q   <= src_a_i;
                                done_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    MUL: begin
                        if (mul_cnt == CW'(MUL_STAGES - 1)) begin
                            {hi_q, lo_q} <= prod_last;
                            done_q       <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            mul_cnt <= mul_cnt + 1'b1;
                        end
                    end
                    DIV: begin
                        if (div_done) begin
                            hi_q   <= div_r;
                            lo_q   <= div_q;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy_o = (start_i & op_is_md(op_i) & ~flush_i & (state == IDLE)) | (state != IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit (WIDTH=32, MUL_STAGES=2).
module tb_hilo_muldiv_unit;

    logic        clka = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] src_a_i, src_b_i;
    logic        flush_i;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int n_pass = 0;
    int n_chk  = 0;

    hilo_muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
        .clka    (clka),
        .rst     (rst),
        .start_i (start_i),
        .op_i    (op_i),
        .src_a_i (src_a_i),
        .src_b_i (src_b_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clka = ~clka;

    // Issue op in cycle 0 and observe 45 cycles. Operands are scrambled after cycle 0;
    // flush_cyc/intr_cyc (-1 = none) pulse flush_i or a stray MTLO start in that cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_cyc, input int intr_cyc,
                          output int done_cyc, output int done_cnt, output int busy_last);
        done_cyc  = -1;
        done_cnt  = 0;
        busy_last = -1;
        for (int c = 0; c < 45; c++) begin
            @(posedge clka);
            #1;
            start_i = (c == 0) || (c == intr_cyc);
            op_i    = (c == 0) ? op : 3'd5;
            src_a_i = (c == 0) ? a : 32'h5555_5555;
            src_b_i = (c == 0) ? b : 32'h0000_0003;
            flush_i = (c == flush_cyc);
            @(negedge clka);
            if (busy_o) busy_last = c;
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
        end
        start_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        int dc, dn, bl;
        n_chk++; if (hi_o !== 32'h0) $display("FAIL reset_hi got %h want 0", hi_o); else n_pass++;
        n_chk++; if (lo_o !== 32'h0) $display("FAIL reset_lo got %h want 0", lo_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
        n_chk++; if (done_o !== 1'b0) $display("FAIL reset_done got %b want 0", done_o); else n_pass++;
        run_op(3'd4, 32'h0000_AAAA, 32'h0, -1, -1, dc, dn, bl);
        run_op(3'd5, 32'h0000_BBBB, 32'h0, -1, -1, dc, dn, bl);
        @(posedge clka); #1;
        start_i = 1'b1; op_i = 3'd3; src_a_i = 32'd100; src_b_i = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clka); #1;
            start_i = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        n_chk++; if (hi_o !== 32'h0) $display("FAIL midreset_hi got %h want 0", hi_o); else n_pass++;
        n_chk++; if (lo_o !== 32'h0) $display("FAIL midreset_lo got %h want 0", lo_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy_o); else n_pass++;
        @(negedge clka);
        rst = 1'b1;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clka);
            if (done_o) dn++;
        end
        n_chk++; if (dn !== 0) $display("FAIL midreset_no_done got %0d pulses want 0", dn); else n_pass++;
    endtask

    task automatic test_mult();
        int dc, dn, bl;
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, -1, -1, dc, dn, bl);
        n_chk++; if (dc !== 2) $display("FAIL mult_done_cyc got %0d want 2", dc); else n_pass++;
        n_chk++; if (bl !== 1) $display("FAIL mult_busy_last got %0d want 1", bl); else n_pass++;
        n_chk++; if (hi_o !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want ffffffff", hi_o); else n_pass++;
        n_chk++; if (lo_o !== 32'hFFFF_FFEB) $display("FAIL mult_lo got %h want ffffffeb", lo_o); else n_pass++;
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, -1, -1, dc, dn, bl);
        n_chk++; if (dn !== 1) $display("FAIL multu_done_cnt got %0d want 1", dn); else n_pass++;
        n_chk++; if (hi_o !== 32'h1) $display("FAIL multu_hi got %h want 1", hi_o); else n_pass++;
        n_chk++; if (lo_o !== 32'hFFFF_FFFE) $display("FAIL multu_lo got %h want fffffffe", lo_o); else n_pass++;
    endtask

    task automatic test_div();
        int dc, dn, bl;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, -1, dc, dn, bl);
        n_chk++; if (dc !== 33) $display("FAIL div_done_cyc got %0d want 33", dc); else n_pass++;
        n_chk++; if (bl !== 32) $display("FAIL div_busy_last got %0d want 32", bl); else n_pass++;
        n_chk++; if (dn !== 1) $display("FAIL div_done_cnt got %0d want 1", dn); else n_pass++;
        n_chk++; if (lo_o !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h want fffffffd", lo_o); else n_pass++;
        n_chk++; if (hi_o !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h want ffffffff", hi_o); else n_pass++;
        run_op(3'd3, 32'd100, 32'd7, -1, -1, dc, dn, bl);
        n_chk++; if (lo_o !== 32'd14) $display("FAIL divu_lo got %h want e", lo_o); else n_pass++;
        n_chk++; if (hi_o !== 32'd2) $display("FAIL divu_hi got %h want 2", hi_o); else n_pass++;
    endtask

    task automatic test_div_edge();
        int dc, dn, bl;
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, dc, dn, bl);
        n_chk++; if (lo_o !== 32'h8000_0000) $display("FAIL divovf_lo got %h want 80000000", lo_o); else n_pass++;
        n_chk++; if (hi_o !== 32'h0) $display("FAIL divovf_hi got %h want 0", hi_o); else n_pass++;
        run_op(3'd3, 32'd5, 32'd0, -1, -1, dc, dn, bl);
        n_chk++; if (dc !== 1) $display("FAIL divzero_done_cyc got %0d want 1", dc); else n_pass++;
        n_chk++; if (bl !== 0) $display("FAIL divzero_busy_last got %0d want 0", bl); else n_pass++;
        n_chk++; if (hi_o !== 32'd5) $display("FAIL divzero_hi got %h want 5", hi_o); else n_pass++;
        n_chk++; if (lo_o !== 32'hFFFF_FFFF) $display("FAIL divzero_lo got %h want ffffffff", lo_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] done_seen = '0;
        logic       busy_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clka); #1;
            start_i = (c < 2);
            op_i    = (c == 0) ? 3'd4 : 3'd5;
            src_a_i = (c == 0) ? 32'h1234_5678 : 32'h9ABC_DEF0;
            @(negedge clka);
            done_seen[c] = done_o;
            busy_seen    = busy_seen | busy_o;
        end
        start_i = 1'b0;
        n_chk++; if (busy_seen !== 1'b0) $display("FAIL mt_busy got %b want 0", busy_seen); else n_pass++;
        n_chk++; if (done_seen !== 4'b0110) $display("FAIL mt_done_pattern got %b want 0110", done_seen); else n_pass++;
        n_chk++; if (hi_o !== 32'h1234_5678) $display("FAIL mt_hi got %h want 12345678", hi_o); else n_pass++;
        n_chk++; if (lo_o !== 32'h9ABC_DEF0) $display("FAIL mt_lo got %h want 9abcdef0", lo_o); else n_pass++;
    endtask

    task automatic test_flush();
        int dc, dn, bl;
        run_op(3'd1, 32'd3, 32'd5, -1, -1, dc, dn, bl);
        n_chk++; if (lo_o !== 32'd15) $display("FAIL flush_setup_lo got %h want f", lo_o); else n_pass++;
        run_op(3'd2, 32'd100, 32'd7, 5, -1, dc, dn, bl);
        n_chk++; if (bl !== 5) $display("FAIL flush_busy_last got %0d want 5", bl); else n_pass++;
        n_chk++; if (dn !== 0) $display("FAIL flush_no_done got %0d want 0", dn); else n_pass++;
        n_chk++; if (hi_o !== 32'h0 || lo_o !== 32'd15)
            $display("FAIL flush_hilo got %h_%h want 00000000_0000000f", hi_o, lo_o); else n_pass++;
        run_op(3'd3, 32'd100, 32'd7, 0, -1, dc, dn, bl);
        n_chk++; if (bl !== -1) $display("FAIL flushstart_busy got %0d want -1", bl); else n_pass++;
        n_chk++; if (dn !== 0) $display("FAIL flushstart_no_done got %0d want 0", dn); else n_pass++;
        run_op(3'd4, 32'hDEAD_BEEF, 32'd0, 0, -1, dc, dn, bl);
        n_chk++; if (hi_o !== 32'h0) $display("FAIL flushstart_mthi got %h want 0", hi_o); else n_pass++;
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 2, -1, dc, dn, bl);
        n_chk++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFEB)
            $display("FAIL flushdone_hilo got %h_%h want ffffffff_ffffffeb", hi_o, lo_o); else n_pass++;
        run_op(3'd3, 32'd100, 32'd7, -1, 3, dc, dn, bl);
        n_chk++; if (dc !== 33 || dn !== 1) $display("FAIL busystart_done got cyc %0d cnt %0d want 33 1", dc, dn); else n_pass++;
        n_chk++; if (lo_o !== 32'd14 || hi_o !== 32'd2)
            $display("FAIL busystart_hilo got %h_%h want 00000002_0000000e", hi_o, lo_o); else n_pass++;
    endtask

    initial begin
        rst = 1'b0; start_i = 1'b0; op_i = 3'd7; src_a_i = '0; src_b_i = '0; flush_i = 1'b0;
        #12 rst = 1'b1;
        @(negedge clka);
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_back_to_back();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
